// File: rtl/game_judge_if.sv
// game_judge_if: evaluation handshake between the board source, game_judge and print_result.
// The master drives start/board/ready. The slave (game_judge) returns the verdict and req.
interface game_judge_if;
    logic        start;
    logic [17:0] board;
    logic        ready;
    logic        req;
    logic        win_a;
    logic        win_b;
    logic        draw;
    logic        busy;

    modport master (
        output start, board, ready,
        input  req, win_a, win_b, draw, busy
    );

    modport slave (
        input  start, board, ready,
        output req, win_a, win_b, draw, busy
    );
endinterface

// File: rtl/game_judge.sv
// game_judge: on start, captures a 3x3 board and scans the 8 winning lines one per
// clock. It then issues a one-cycle req to print_result once ready is seen.
// The verdict flags are held until the next accepted start.
// Optional full-board draw detection is enabled by defining GAME_JUDGE_DRAW_EN.
module game_judge (
    input  logic        clk,
    input  logic        reset,
    game_judge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_e;

    state_e          state_q, state_d;
    logic [17:0]     board_q, board_d;
    logic [2:0]      idx_q, idx_d;
    logic            win_a_q, win_a_d;
    logic            win_b_q, win_b_d;
    logic            req_q, req_d;
    logic [8:0][1:0] cells;
    logic [3:0]      c0, c1, c2;
    logic            line_a, line_b;
`ifdef GAME_JUDGE_DRAW_EN
    logic            draw_q, draw_d;
    logic            full;
`endif

    assign cells = board_q;

    // Map the current line index to its three cell positions.
    always_comb begin
        c0 = 4'd0;
        c1 = 4'd0;
        c2 = 4'd0;
        case (idx_q)
            3'd0:    begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
            3'd1:    begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
            3'd2:    begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
            3'd3:    begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
            3'd4:    begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
            3'd5:    begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
            3'd6:    begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
            default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
        endcase
    end

    assign line_a = (cells[c0] == 2'b01) && (cells[c1] == 2'b01) && (cells[c2] == 2'b01);
    assign line_b = (cells[c0] == 2'b10) && (cells[c1] == 2'b10) && (cells[c2] == 2'b10);

`ifdef GAME_JUDGE_DRAW_EN
    // Board is full when every cell is owned by exactly one player (01 or 10).
    always_comb begin
        full = 1'b1;
        for (int unsigned i = 0; i < 9; i++) begin
            full = full & (cells[i][1] ^ cells[i][0]);
        end
    end
`endif

    // Next-state, line scan and report handshake.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        idx_d   = idx_q;
        win_a_d = win_a_q;
        win_b_d = win_b_q;
        req_d   = 1'b0;
`ifdef GAME_JUDGE_DRAW_EN
        draw_d  = draw_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    board_d = bus.board;
                    win_a_d = 1'b0;
                    win_b_d = 1'b0;
`ifdef GAME_JUDGE_DRAW_EN
                    draw_d  = 1'b0;
`endif
                    idx_d   = 3'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (line_a) win_a_d = 1'b1;
                if (line_b) win_b_d = 1'b1;
                if (idx_q == 3'd7) begin
                    // The draw decision must see the win flags from this final line too.
`ifdef GAME_JUDGE_DRAW_EN
                    draw_d = full && !win_a_d && !win_b_d;
`endif
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            REPORT: begin
                if (bus.ready) begin
                    req_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any evaluation in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            board_q <= '0;
            idx_q   <= '0;
            win_a_q <= 1'b0;
            win_b_q <= 1'b0;
            req_q   <= 1'b0;
`ifdef GAME_JUDGE_DRAW_EN
            draw_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            idx_q   <= idx_d;
            win_a_q <= win_a_d;
            win_b_q <= win_b_d;
            req_q   <= req_d;
`ifdef GAME_JUDGE_DRAW_EN
            draw_q  <= draw_d;
`endif
        end
    end

    assign bus.req   = req_q;
    assign bus.win_a = win_a_q;
    assign bus.win_b = win_b_q;
    assign bus.busy  = (state_q != IDLE);
`ifdef GAME_JUDGE_DRAW_EN
    assign bus.draw  = draw_q;
`else
    assign bus.draw  = 1'b0;
`endif
endmodule

// File: doc/game_judge.md
# game_judge

Board-evaluation stage directly upstream of `print_result`. On a `start` pulse it captures a 3x3 tic-tac-toe board and scans the 8 winning lines sequentially, one per clock. It sets `win_a`/`win_b` (and `draw` when configured), then issues a one-cycle `req` to `print_result` once that block reports `ready`. Results are held stable until the next accepted `start`, so the downstream UART message always reflects a consistent verdict.

## Interface
Parameters: none.

- `clk`  in  1  system clock; only clock.
- `reset`  in  1  **asynchronous, active-low** reset; asserting it (low) clears all state immediately.
- `start`  in  1  evaluate request; sampled only in IDLE.
- `board`  in  18  cell i at `board[2i+1:2i]`, i = row*3+col. Encoding: 00 empty, 01 player A, 10 player B, 11 illegal (treated as empty).
- `ready`  in  1  from `print_result`: can accept `req`.
- `req`  out  1  one-cycle request to `print_result`.
- `win_a`  out  1  A owns at least one line.
- `win_b`  out  1  B owns at least one line.
- `draw`  out  1  board full, no winner (see Configuration).
- `busy`  out  1  high in SCAN and REPORT.

## Operation
- States: IDLE, SCAN, REPORT.
- **IDLE:**
  - On a `start`=1 edge: capture `board` into `board_q`, clear `win_a`/`win_b`/`draw`, set line index `idx`=0, go to SCAN.
  - After capture, later changes on `board` have no effect on the current evaluation.
- **SCAN:** evaluates line `idx` per edge.
  - Line map: 0-2 rows 0-2; 3-5 columns 0-2; 6 diagonal {0,4,8}; 7 anti-diagonal {2,4,6}.
  - If all 3 cells are 01, set `win_a`. If all 3 are 10, set `win_b`. Flags are sticky.
  - `idx` is 3 bits. On the edge evaluating `idx`=7: compute `draw` and go to REPORT. `idx` does not wrap into a new scan.
- **Conflict board** (lines for both A and B): both flags set; no priority, no early exit.
- **REPORT:** on an edge with `ready`=1, drive `req`<=1 and go to IDLE. While `ready`=0, wait indefinitely with `req`=0.
- `start` in SCAN or REPORT is ignored; it is not queued.
- `win_a`, `win_b`, `draw` are registered. They hold from the end of SCAN until the next accepted `start`, covering the whole `print_result` transaction.

## Timing
- Reset values: `req`=0, `win_a`=0, `win_b`=0, `draw`=0, `busy`=0, state IDLE.
- Reset mid-scan or mid-REPORT aborts at once; no `req` is issued.
- Let E0 be the edge sampling `start`=1:
  - E1..E8 evaluate lines 0..7.
  - Final flags are visible after E8.
  - State is REPORT after E8.
- Earliest `req`: high in the cycle after E9 (when `ready`=1 at E9), low after E10.
- `req` is never high two consecutive cycles.
- `busy` rises after E0 and falls on the same edge that raises `req`.
- A `start` arriving while `req` is high is accepted; new-evaluation flags clear on that edge.

## Configuration
- Macro `GAME_JUDGE_DRAW_EN`.
- **Defined:** `draw` is set at end of SCAN iff every cell of `board_q` is 01 or 10 and neither win flag is set.
- **Undefined:** `draw` is tied to 0, and the full-board check logic is not synthesized. All other behaviour is identical.

## Test plan
- **Reset:** hold `reset`=0 for 10 cycles with `start`=1 → all outputs 0; no `req`.
- **Row 0 to A:** `board`=18'h00015, `ready`=1, `start` pulse at E0 → `win_a`=1, `win_b`=0 after E8; `req` high exactly one cycle after E9; `busy` low afterwards.
- **Anti-diagonal to B:** `board`=18'h02220 → `win_b`=1, `win_a`=0, `draw`=0. Also hold `ready`=0 for 20 cycles → `req` waits; flags stable; `req` pulses 1 cycle after `ready` rises.
- **Full board, no winner:** `board`=18'h16A59 → `win_a`=`win_b`=0. `draw`=1 with `GAME_JUDGE_DRAW_EN` defined; `draw`=0 without it.
- **Conflict board:** `board`=18'h00A95 (row 0 A, row 1 B) → `win_a`=`win_b`=1; single `req`.
- **Ignored start and abort:**
  - `start` pulse at E3 during SCAN and a `board` change at E4 → result matches the captured board; one `req` only.
  - Separately, `reset`=0 at E5 → no `req`; all outputs 0.
